i2q2_computer: RTL

- Sits directly upstream of the acquisition controller in each channel.
- On each accumulation_complete it captures the early/prompt/late I and Q accumulator dumps and computes I²+Q² for each tap.
- Uses one shared, pipelined multiplier.
- Publishes all three powers atomically with a one-cycle i2q2_valid pulse, then holds them constant until the next result.

---
 rtl/i2q2_computer_pkg.sv | 40 ++++
 rtl/i2q2_computer_square_pipe.sv | 66 ++++++
 rtl/i2q2_computer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/i2q2_computer_pkg.sv
// Shared definitions for the I^2+Q^2 power computer.
//   - Default accumulator/result widths. They must agree with the acquisition
//     controller's I2Q2_RANGE.
//   - FSM state encoding, exposed on the top-level dbg_state port.
//   - Tap select encoding (0/1/2 = early/prompt/late). It matches the
//     controller's i2q2_sel.
//   - Helpers that decode the 3-bit operand tag carried through the multiplier.
package i2q2_computer_pkg;

  localparam int ACC_WIDTH_DEF   = 20;
  localparam int I2Q2_WIDTH_DEF  = 2 * ACC_WIDTH_DEF;
  localparam int MULT_STAGES_DEF = 2;

  // Six operands per result: i_e, q_e, i_p, q_p, i_l, q_l.
  localparam int         NUM_OPERANDS = 6;
  localparam logic [2:0] LAST_OPERAND = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  localparam logic [1:0] TAP_EARLY  = 2'd0;
  localparam logic [1:0] TAP_PROMPT = 2'd1;
  localparam logic [1:0] TAP_LATE   = 2'd2;

  // Operand tag = issue index.
  //   tag[2:1] selects the tap.
  //   tag[0] distinguishes I (0, loads the sum) from Q (1, adds to the sum).
  function automatic logic [1:0] tag_to_tap(input logic [2:0] tag);
    return tag[2:1];
  endfunction

  function automatic logic tag_is_q(input logic [2:0] tag);
    return tag[0];
  endfunction

endpackage

// File: rtl/i2q2_computer_square_pipe.sv
// Shared squaring pipeline.
// It squares a signed accumulator dump and delivers the unsigned result
// MULT_STAGES cycles later. A valid bit and a 3-bit operand tag travel with
// the data.
// Ports:
//   clk, global_reset_n : clock, synchronous active-low reset
//   clear               : drops every in-flight valid bit (flush)
//   in_valid/in_tag/in_operand    : operand issue
//   out_valid/out_tag/out_square  : retired product
//
// Valid/ready contract: there is no backpressure.
//   - An operand presented with in_valid=1 is always accepted.
//   - It emerges with out_valid=1 exactly MULT_STAGES cycles later, unless
//     clear is asserted while it is in flight.
module i2q2_computer_square_pipe #(
  parameter int ACC_WIDTH   = 20,
  parameter int I2Q2_WIDTH  = 2 * ACC_WIDTH,
  parameter int MULT_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        global_reset_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [2:0]                  in_tag,
  input  logic signed [ACC_WIDTH-1:0] in_operand,
  output logic                        out_valid,
  output logic [2:0]                  out_tag,
  output logic [I2Q2_WIDTH-1:0]       out_square
);

  logic signed [I2Q2_WIDTH-1:0] op_ext;
  logic signed [I2Q2_WIDTH-1:0] square;

  // Sign-extend first so the product is formed from the signed operand.
  // The magnitude is at most 2^(2*ACC_WIDTH-2), so nothing is lost.
  assign op_ext = {{(I2Q2_WIDTH-ACC_WIDTH){in_operand[ACC_WIDTH-1]}}, in_operand};
  assign square = op_ext * op_ext;

  logic [MULT_STAGES-1:0] v_q;
  logic [2:0]             tag_q [MULT_STAGES];
  logic [I2Q2_WIDTH-1:0]  sq_q  [MULT_STAGES];

  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      v_q <= '0;
      for (int s = 0; s < MULT_STAGES; s++) begin
        tag_q[s] <= '0;
        sq_q[s]  <= '0;
      end
    end else begin
      v_q[0]   <= in_valid && !clear;
      tag_q[0] <= in_tag;
      sq_q[0]  <= $unsigned(square);
      for (int s = 1; s < MULT_STAGES; s++) begin
        v_q[s]   <= v_q[s-1] && !clear;
        tag_q[s] <= tag_q[s-1];
        sq_q[s]  <= sq_q[s-1];
      end
    end
  end

  assign out_valid  = v_q[MULT_STAGES-1];
  assign out_tag    = tag_q[MULT_STAGES-1];
  assign out_square = sq_q[MULT_STAGES-1];

endmodule

// File: rtl/i2q2_computer.sv
// I^2+Q^2 power computer for one channel.
// It captures the early/prompt/late I/Q dumps on accumulation_complete, then
// squares and sums them through one shared pipelined multiplier. All three
// powers are published together with a one-cycle i2q2_valid pulse and held
// until the next result.
// Ports:
//   clk, global_reset_n   : clock, synchronous active-low reset
//   accumulation_complete : strobe; the six dumps are valid this cycle
//   flush                 : abort in-flight and pending work
//   i_/q_{early,prompt,late}      : signed accumulator dumps
//   i2q2_{early,prompt,late}      : published powers, held between updates
//   i2q2_valid            : one-cycle strobe; new powers visible this cycle
//   busy                  : computation in progress or pending
//   overrun               : one-cycle strobe; pending capture was overwritten
//   dbg_state             : current FSM state
module i2q2_computer
  import i2q2_computer_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int I2Q2_WIDTH  = 2 * ACC_WIDTH,
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic                        clk,
  input  logic                        global_reset_n,
  input  logic                        accumulation_complete,
  input  logic                        flush,
  input  logic signed [ACC_WIDTH-1:0] i_early,
  input  logic signed [ACC_WIDTH-1:0] q_early,
  input  logic signed [ACC_WIDTH-1:0] i_prompt,
  input  logic signed [ACC_WIDTH-1:0] q_prompt,
  input  logic signed [ACC_WIDTH-1:0] i_late,
  input  logic signed [ACC_WIDTH-1:0] q_late,
  output logic [I2Q2_WIDTH-1:0]       i2q2_early,
  output logic [I2Q2_WIDTH-1:0]       i2q2_prompt,
  output logic [I2Q2_WIDTH-1:0]       i2q2_late,
  output logic                        i2q2_valid,
  output logic                        busy,
  output logic                        overrun,
  output state_t                      dbg_state
);

  localparam int             DCW        = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MULT_STAGES - 1);

  logic signed [ACC_WIDTH-1:0] cap_d  [NUM_OPERANDS];
  logic signed [ACC_WIDTH-1:0] pend_q [NUM_OPERANDS];
  logic signed [ACC_WIDTH-1:0] work_q [NUM_OPERANDS];

  state_t                state_q, state_d;
  logic                  pending_q, overrun_q;
  logic [2:0]            idx_q;
  logic [DCW-1:0]        drain_q;
  logic                  capture, transfer, publish_load;
  logic                  issue_valid;
  logic signed [ACC_WIDTH-1:0] issue_operand;
  logic                  pipe_valid;
  logic [2:0]            pipe_tag;
  logic [I2Q2_WIDTH-1:0] pipe_square;
  logic [I2Q2_WIDTH-1:0] sum_q [3];
  logic [I2Q2_WIDTH-1:0] sum_d [3];
  logic [I2Q2_WIDTH-1:0] early_q, prompt_q, late_q;

  assign cap_d[0] = i_early;
  assign cap_d[1] = q_early;
  assign cap_d[2] = i_prompt;
  assign cap_d[3] = q_prompt;
  assign cap_d[4] = i_late;
  assign cap_d[5] = q_late;

  // flush wins over a same-cycle strobe, which is dropped.
  assign capture  = accumulation_complete && !flush;
  assign transfer = (state_q == ST_IDLE) && pending_q && !flush;

  always_comb begin
    state_d      = state_q;
    issue_valid  = 1'b0;
    publish_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        if (idx_q == LAST_OPERAND) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last product retires in the final DRAIN cycle.
        // The outputs load from the next-sum value, so the new powers are
        // already visible in the PUBLISH cycle alongside i2q2_valid.
        if (drain_q == DRAIN_LAST) begin
          state_d      = ST_PUBLISH;
          publish_load = 1'b1;
        end
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d      = ST_IDLE;
      issue_valid  = 1'b0;
      publish_load = 1'b0;
    end
  end

  always_comb begin
    issue_operand = '0;
    case (idx_q)
      3'd0:    issue_operand = work_q[0];
      3'd1:    issue_operand = work_q[1];
      3'd2:    issue_operand = work_q[2];
      3'd3:    issue_operand = work_q[3];
      3'd4:    issue_operand = work_q[4];
      3'd5:    issue_operand = work_q[5];
      default: issue_operand = '0;
    endcase
  end

  i2q2_computer_square_pipe #(
    .ACC_WIDTH   (ACC_WIDTH),
    .I2Q2_WIDTH  (I2Q2_WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_square_pipe (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .clear          (flush),
    .in_valid       (issue_valid),
    .in_tag         (idx_q),
    .in_operand     (issue_operand),
    .out_valid      (pipe_valid),
    .out_tag        (pipe_tag),
    .out_square     (pipe_square)
  );

  // The I^2 product (even tag) loads the tap sum.
  // The Q^2 product (odd tag) adds to it.
  always_comb begin
    for (int t = 0; t < 3; t++) sum_d[t] = sum_q[t];
    if (pipe_valid) begin
      case (tag_to_tap(pipe_tag))
        TAP_EARLY:  sum_d[0] = tag_is_q(pipe_tag) ? sum_q[0] + pipe_square : pipe_square;
        TAP_PROMPT: sum_d[1] = tag_is_q(pipe_tag) ? sum_q[1] + pipe_square : pipe_square;
        TAP_LATE:   sum_d[2] = tag_is_q(pipe_tag) ? sum_q[2] + pipe_square : pipe_square;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= 3'd0;
      drain_q   <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        pend_q[i] <= '0;
        work_q[i] <= '0;
      end
      for (int t = 0; t < 3; t++) sum_q[t] <= '0;
      early_q   <= '0;
      prompt_q  <= '0;
      late_q    <= '0;
    end else begin
      state_q <= state_d;
      // Overwriting a pending capture is an overrun.
      // The exception is when the old data moves to the working buffer in
      // this same cycle: nothing is lost then.
      overrun_q <= capture && pending_q && !transfer;
      if (flush)         pending_q <= 1'b0;
      else if (capture)  pending_q <= 1'b1;
      else if (transfer) pending_q <= 1'b0;
      if (capture) begin
        for (int i = 0; i < NUM_OPERANDS; i++) pend_q[i] <= cap_d[i];
      end
      if (transfer) begin
        for (int i = 0; i < NUM_OPERANDS; i++) work_q[i] <= pend_q[i];
      end
      idx_q   <= (state_q == ST_ISSUE && state_d == ST_ISSUE) ? idx_q + 3'd1 : 3'd0;
      drain_q <= (state_q == ST_DRAIN && state_d == ST_DRAIN) ? drain_q + DCW'(1) : '0;
      for (int t = 0; t < 3; t++) sum_q[t] <= sum_d[t];
      if (publish_load) begin
        early_q  <= sum_d[0];
        prompt_q <= sum_d[1];
        late_q   <= sum_d[2];
      end
    end
  end

  assign i2q2_early  = early_q;
  assign i2q2_prompt = prompt_q;
  assign i2q2_late   = late_q;
  assign i2q2_valid  = (state_q == ST_PUBLISH);
  assign busy        = (state_q != ST_IDLE) || pending_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule
